active_list: RTL and testbench
==============================

# active_list

In-order active list (reorder tracker) for the renamed pipeline. It sits at the opposite end of the decode-to-execute path from the decode stage. Decode allocates an entry and carries the returned index downstream as the instruction's active-list index. Writeback marks entries complete. This block retires them in program order and returns the previous physical register to the free list.

## Interface
- FREE_LIST_WIDTH, 3: index width; depth = 2**FREE_LIST_WIDTH (8)
- VREG_WIDTH, 5: architectural register address width
- PREG_WIDTH, 6: physical register address width

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset; asynchronous, active-high
- global_flush  input  1  discard all entries
- alloc_req  input  1  decode requests an entry this cycle
- alloc_wb_reg  input  1  instruction writes a register
- alloc_vreg  input  VREG_WIDTH  destination architectural register
- alloc_preg  input  PREG_WIDTH  newly mapped physical register
- alloc_old_preg  input  PREG_WIDTH  physical register previously mapped to alloc_vreg
- alloc_index  output  FREE_LIST_WIDTH  index granted to the current request; combinational, equals tail
- full  output  1  count == depth; combinational
- empty  output  1  count == 0; combinational
- complete_valid  input  1  writeback reports completion
- complete_index  input  FREE_LIST_WIDTH  entry being completed
- complete_exception  input  1  completed instruction trapped or was illegal
- retire_valid  output  1  registered one-cycle pulse: an entry retired
- retire_index  output  FREE_LIST_WIDTH  retired entry
- retire_wb_reg  output  1  retired entry wrote a register
- retire_vreg  output  VREG_WIDTH  architectural destination of the retired entry
- retire_preg  output  PREG_WIDTH  physical register that becomes architectural
- retire_free_preg  output  PREG_WIDTH  old physical register to return to the free list; valid only when retire_valid and retire_wb_reg
- exception_flush  output  1  registered one-cycle pulse: the retired entry carried an exception

## Operation
- State per entry: valid, done, exception, wb_reg, vreg, preg, old_preg. Also head, tail (FREE_LIST_WIDTH bits, wrapping) and count (FREE_LIST_WIDTH+1 bits).
- Allocate: when alloc_req and !full, write the entry at tail as valid=1, done=0, exception=0, plus the payload. Then tail+1 and count+1. When full, alloc_req is ignored; decode must stall on full.
- Complete: when complete_valid and entry[complete_index].valid, set done=1 and exception=complete_exception. Completion of an invalid entry is ignored.
- Retire: at most one per cycle. When entry[head].valid and entry[head].done:
  - the outputs register that entry with retire_valid=1;
  - the entry is cleared and head advances by 1;
  - count decreases by 1.
- Exception retire: if the head entry has exception=1, it retires as above with exception_flush=1. On the same edge every entry is cleared, head=tail=0 and count=0.
- global_flush: all entries cleared, head=tail=0, count=0. retire_valid and exception_flush are 0 on the next cycle. This overrides alloc, complete and retire in the same cycle.
- Simultaneous events:
  - alloc and retire in one cycle: count is unchanged.
  - full is evaluated on pre-edge count, so a full list refuses alloc even if it retires that cycle.
  - Completing the head entry makes it eligible on the next edge, not the same one.
- Reset: all entry bits, head, tail, count = 0. All registered outputs = 0. Hence alloc_index=0, empty=1, full=0.

## Timing
- Allocate-to-index: alloc_index is valid in the request cycle. The entry becomes valid at the next edge.
- Complete-to-retire: completion captured at edge N; if that entry is the head, retire_valid goes high after edge N+1.
- Retire bandwidth: 1 per cycle. A run of done entries drains on consecutive cycles.
- retire_* and exception_flush hold for exactly one cycle per retire event and are 0 otherwise. retire_* payload is 0 when retire_valid is 0.
- Reset is asynchronous mid-operation: all outputs clear immediately on rst rising, regardless of clk.

## Test plan
- Reset then a single instruction:
  - after reset, empty=1 and alloc_index=0;
  - alloc vreg=5, preg=33, old_preg=5 → index 0, count=1;
  - complete index 0 → two edges later retire_valid=1, retire_vreg=5, retire_preg=33, retire_free_preg=5, then empty=1.
- Fill and wrap: allocate 8 entries → full=1. A 9th alloc_req is ignored (tail unchanged). Complete 0..7 in reverse order → retires 0..7 in order on 8 consecutive cycles. A new alloc then gets index 0 again.
- Out-of-order completion: allocate 3, complete index 2 then index 1 → no retire. Complete index 0 → retires 0, 1, 2 on consecutive cycles.
- Exception: allocate 4, complete index 1 with exception=1, then complete index 0 → retire 0, then retire 1 with exception_flush=1. Next cycle empty=1 and entries 2 and 3 never retire.
- Flush priority: with 3 entries (head done), assert global_flush together with alloc_req and complete_valid → next cycle empty=1, retire_valid=0, alloc_index=0.
- Full with simultaneous retire: list full and head done, assert alloc_req → retire occurs, alloc refused, count=7, full=0 next cycle.

Source files
------------

// File: rtl/active_list.sv
// In-order active list: decode allocates at tail, writeback marks entries done,
// and the head retires in program order, returning the old physical register.
module active_list #(
    parameter int FREE_LIST_WIDTH = 3,
    parameter int VREG_WIDTH      = 5,
    parameter int PREG_WIDTH      = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       global_flush,
    input  logic                       alloc_req,
    input  logic                       alloc_wb_reg,
    input  logic [VREG_WIDTH-1:0]      alloc_vreg,
    input  logic [PREG_WIDTH-1:0]      alloc_preg,
    input  logic [PREG_WIDTH-1:0]      alloc_old_preg,
    output logic [FREE_LIST_WIDTH-1:0] alloc_index,
    output logic                       full,
    output logic                       empty,
    input  logic                       complete_valid,
    input  logic [FREE_LIST_WIDTH-1:0] complete_index,
    input  logic                       complete_exception,
    output logic                       retire_valid,
    output logic [FREE_LIST_WIDTH-1:0] retire_index,
    output logic                       retire_wb_reg,
    output logic [VREG_WIDTH-1:0]      retire_vreg,
    output logic [PREG_WIDTH-1:0]      retire_preg,
    output logic [PREG_WIDTH-1:0]      retire_free_preg,
    output logic                       exception_flush
);

    localparam int DEPTH = 1 << FREE_LIST_WIDTH;
    localparam int CW    = FREE_LIST_WIDTH + 1;

    logic [DEPTH-1:0]           valid_reg;
    logic [DEPTH-1:0]           done_reg;
    logic [DEPTH-1:0]           exc_reg;
    logic [DEPTH-1:0]           wb_reg_reg;
    logic [VREG_WIDTH-1:0]      vreg_reg     [DEPTH];
    logic [PREG_WIDTH-1:0]      preg_reg     [DEPTH];
    logic [PREG_WIDTH-1:0]      old_preg_reg [DEPTH];
    logic [FREE_LIST_WIDTH-1:0] head_reg;
    logic [FREE_LIST_WIDTH-1:0] tail_reg;
    logic [CW-1:0]              count_reg;

    logic             do_alloc;
    logic             do_retire;
    logic             do_exc_retire;
    logic [DEPTH-1:0] alloc_sel;
    logic [DEPTH-1:0] complete_sel;
    logic [DEPTH-1:0] retire_sel;

    assign full          = (count_reg == CW'(DEPTH));
    assign empty         = (count_reg == '0);
    assign alloc_index   = tail_reg;
    assign do_alloc      = alloc_req && !full;
    assign do_retire     = valid_reg[head_reg] && done_reg[head_reg];
    assign do_exc_retire = do_retire && exc_reg[head_reg];

    // Completions only land on live entries; a stale index from writeback is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign alloc_sel[gi]    = do_alloc && (tail_reg == FREE_LIST_WIDTH'(gi));
            assign complete_sel[gi] = complete_valid && valid_reg[gi] &&
                                      (complete_index == FREE_LIST_WIDTH'(gi));
            assign retire_sel[gi]   = do_retire && (head_reg == FREE_LIST_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg  <= '0;
            done_reg   <= '0;
            exc_reg    <= '0;
            wb_reg_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                vreg_reg[i]     <= '0;
                preg_reg[i]     <= '0;
                old_preg_reg[i] <= '0;
            end
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (global_flush || do_exc_retire) begin
            // A trapping instruction squashes everything younger, including this cycle's alloc.
            valid_reg  <= '0;
            done_reg   <= '0;
            exc_reg    <= '0;
            wb_reg_reg <= '0;
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (retire_sel[i]) begin
                    valid_reg[i]  <= 1'b0;
                    done_reg[i]   <= 1'b0;
                    exc_reg[i]    <= 1'b0;
                    wb_reg_reg[i] <= 1'b0;
                end else if (complete_sel[i]) begin
                    done_reg[i] <= 1'b1;
                    exc_reg[i]  <= complete_exception;
                end
                if (alloc_sel[i]) begin
                    valid_reg[i]    <= 1'b1;
                    done_reg[i]     <= 1'b0;
                    exc_reg[i]      <= 1'b0;
                    wb_reg_reg[i]   <= alloc_wb_reg;
                    vreg_reg[i]     <= alloc_vreg;
                    preg_reg[i]     <= alloc_preg;
                    old_preg_reg[i] <= alloc_old_preg;
                end
            end
            if (do_retire) begin
                head_reg <= head_reg + 1'b1;
            end
            if (do_alloc) begin
                tail_reg <= tail_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_alloc) - CW'(do_retire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_valid     <= 1'b0;
            retire_index     <= '0;
            retire_wb_reg    <= 1'b0;
            retire_vreg      <= '0;
            retire_preg      <= '0;
            retire_free_preg <= '0;
            exception_flush  <= 1'b0;
        end else if (global_flush || !do_retire) begin
            retire_valid     <= 1'b0;
            retire_index     <= '0;
            retire_wb_reg    <= 1'b0;
            retire_vreg      <= '0;
            retire_preg      <= '0;
            retire_free_preg <= '0;
            exception_flush  <= 1'b0;
        end else begin
            retire_valid     <= 1'b1;
            retire_index     <= head_reg;
            retire_wb_reg    <= wb_reg_reg[head_reg];
            retire_vreg      <= vreg_reg[head_reg];
            retire_preg      <= preg_reg[head_reg];
            retire_free_preg <= old_preg_reg[head_reg];
            exception_flush  <= exc_reg[head_reg];
        end
    end

endmodule

// File: tb/tb_active_list.sv
// Randomized and directed bench for active_list against a program-order queue model.
module tb_active_list;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       global_flush = 1'b0;
    logic       alloc_req = 1'b0;
    logic       alloc_wb_reg = 1'b0;
    logic [4:0] alloc_vreg = '0;
    logic [5:0] alloc_preg = '0;
    logic [5:0] alloc_old_preg = '0;
    logic [2:0] alloc_index;
    logic       full;
    logic       empty;
    logic       complete_valid = 1'b0;
    logic [2:0] complete_index = '0;
    logic       complete_exception = 1'b0;
    logic       retire_valid;
    logic [2:0] retire_index;
    logic       retire_wb_reg;
    logic [4:0] retire_vreg;
    logic [5:0] retire_preg;
    logic [5:0] retire_free_preg;
    logic       exception_flush;

    int checks = 0;
    int failures = 0;

    active_list dut (
        .clk                (clk),
        .rst                (rst),
        .global_flush       (global_flush),
        .alloc_req          (alloc_req),
        .alloc_wb_reg       (alloc_wb_reg),
        .alloc_vreg         (alloc_vreg),
        .alloc_preg         (alloc_preg),
        .alloc_old_preg     (alloc_old_preg),
        .alloc_index        (alloc_index),
        .full               (full),
        .empty              (empty),
        .complete_valid     (complete_valid),
        .complete_index     (complete_index),
        .complete_exception (complete_exception),
        .retire_valid       (retire_valid),
        .retire_index       (retire_index),
        .retire_wb_reg      (retire_wb_reg),
        .retire_vreg        (retire_vreg),
        .retire_preg        (retire_preg),
        .retire_free_preg   (retire_free_preg),
        .exception_flush    (exception_flush)
    );

    always #5 clk = ~clk;

    // Model: instructions in program order, oldest first.
    typedef struct {
        int  idx;
        bit  done;
        bit  exc;
        bit  wb;
        int  v;
        int  p;
        int  op;
    } ent_t;

    ent_t q[$];
    int   m_tail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tail = 0;
    endtask

    // One clock cycle: drive inputs, check combinational status, advance model, check retire outputs.
    task automatic cycle(input bit fl, input bit ar, input bit wb, input int v, input int p,
                         input int op, input bit cv, input int ci, input bit ce);
        bit   pre_full;
        bit   ret;
        ent_t r;
        bit   e_rv = 0, e_wb = 0, e_ef = 0;
        int   e_idx = 0, e_v = 0, e_p = 0, e_op = 0;

        global_flush       = fl;
        alloc_req          = ar;
        alloc_wb_reg       = wb;
        alloc_vreg         = 5'(v);
        alloc_preg         = 6'(p);
        alloc_old_preg     = 6'(op);
        complete_valid     = cv;
        complete_index     = 3'(ci);
        complete_exception = ce;
        #1;
        pre_full = (q.size() == 8);
        chk("alloc_index", 32'(alloc_index), 32'(m_tail));
        chk("full", 32'(full), 32'(pre_full));
        chk("empty", 32'(empty), 32'(q.size() == 0));

        if (fl) begin
            model_reset();
        end else begin
            ret = (q.size() > 0) && q[0].done;
            if (ret) r = q[0];
            if (cv) begin
                foreach (q[k]) begin
                    if (q[k].idx == ci) begin
                        q[k].done = 1'b1;
                        q[k].exc  = ce;
                    end
                end
            end
            if (ret) begin
                e_rv = 1; e_idx = r.idx; e_wb = r.wb; e_v = r.v; e_p = r.p; e_op = r.op; e_ef = r.exc;
                if (r.exc) model_reset();
                else void'(q.pop_front());
            end
            if (ar && !pre_full && !(ret && r.exc)) begin
                q.push_back('{idx: m_tail, done: 0, exc: 0, wb: wb, v: v, p: p, op: op});
                m_tail = (m_tail + 1) % 8;
            end
        end

        @(posedge clk);
        #1;
        chk("retire_valid", 32'(retire_valid), 32'(e_rv));
        chk("retire_index", 32'(retire_index), 32'(e_idx));
        chk("retire_wb_reg", 32'(retire_wb_reg), 32'(e_wb));
        chk("retire_vreg", 32'(retire_vreg), 32'(e_v));
        chk("retire_preg", 32'(retire_preg), 32'(e_p));
        if (!e_rv || e_wb) chk("retire_free_preg", 32'(retire_free_preg), 32'(e_op));
        chk("exception_flush", 32'(exception_flush), 32'(e_ef));
        $display("cyc fl=%0b ar=%0b cv=%0b ci=%0d ce=%0b -> rv=%0b ridx=%0d ef=%0b occ=%0d",
                 fl, ar, cv, ci, ce, retire_valid, retire_index, exception_flush, q.size());
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input int v, input int p, input int op);
        cycle(0, 1, 1, v, p, op, 0, 0, 0);
    endtask

    task automatic complete(input int ci, input bit ce);
        cycle(0, 0, 0, 0, 0, 0, 1, ci, ce);
    endtask

    task automatic flush();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_alloc_index", 32'(alloc_index), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_retire_valid", 32'(retire_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single instruction
        alloc(5, 33, 5);
        complete(0, 0);
        idle();
        idle();

        // Fill, refused 9th alloc, reverse completion, in-order drain, wrap to index 0
        for (int i = 0; i < 8; i++) alloc(i + 1, 10 + i, 40 + i);
        alloc(31, 63, 63);
        for (int i = 7; i >= 0; i--) complete(i, 0);
        for (int i = 0; i < 9; i++) idle();
        alloc(3, 7, 9);
        flush();

        // Out-of-order completion
        for (int i = 0; i < 3; i++) alloc(i, 20 + i, 30 + i);
        complete(2, 0);
        complete(1, 0);
        idle();
        complete(0, 0);
        for (int i = 0; i < 4; i++) idle();

        // Exception: younger entries 2 and 3 must never retire
        flush();
        for (int i = 0; i < 4; i++) alloc(i + 8, 40 + i, 50 + i);
        complete(1, 1);
        complete(0, 0);
        complete(2, 0);
        complete(3, 0);
        for (int i = 0; i < 3; i++) idle();

        // Flush overrides alloc, complete and a ready retire
        for (int i = 0; i < 3; i++) alloc(i, i, i);
        complete(0, 0);
        cycle(1, 1, 1, 7, 7, 7, 1, 1, 0);
        idle();

        // Full list with head done: alloc refused while retiring
        for (int i = 0; i < 8; i++) alloc(i, 48 + i, i);
        complete(0, 0);
        cycle(0, 1, 1, 9, 9, 9, 0, 0, 0);
        idle();
        flush();

        // Asynchronous reset while a retire pulse is visible
        alloc(4, 44, 14);
        complete(0, 0);
        idle();
        rst = 1'b1;
        #1;
        chk("arst_retire_valid", 32'(retire_valid), 32'd0);
        chk("arst_retire_preg", 32'(retire_preg), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_alloc_index", 32'(alloc_index), 32'd0);
        #1;
        rst = 1'b0;
        model_reset();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit fl = ($urandom_range(0, 99) < 2);
            bit ar = ($urandom_range(0, 99) < 60);
            bit cv = ($urandom_range(0, 99) < 55);
            bit ce = ($urandom_range(0, 99) < 5);
            int ci = $urandom_range(0, 7);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) ci = q[$urandom_range(0, q.size() - 1)].idx;
            cycle(fl, ar, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 63),
                  $urandom_range(0, 63), cv, ci, ce);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
